// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchroniser, 11-bit deframer with timeout, scan-code FIFO and key tracker.
// Optional define PS2_PARITY_CHECK_EN enables odd-parity checking of received frames.
module ps2_kbd_rx #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_down,
    output logic [7:0] key_count
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    logic clk_s1, clk_s2, clk_d;
    logic data_s1, data_s2;
    logic fall;

    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic [TW-1:0] tmo_cnt;
    logic          push_pend;
    logic [7:0]    push_byte;
    logic          frame_ok;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             full, pop, push;
    logic             break_pend;

    // Lines idle high, so the synchroniser resets high to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_d   <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_d   <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall = clk_d & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    always_ff @(posedge clk) begin
        if (rst)
            par_bit <= 1'b0;
        else if (fall && bit_cnt == 4'd9)
            par_bit <= data_s2;
    end
    assign frame_ok = data_s2 & (^{shift, par_bit});
`else
    assign frame_ok = data_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            tmo_cnt   <= '0;
            push_pend <= 1'b0;
            push_byte <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!data_s2)
                        bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shift   <= {data_s2, shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    bit_cnt <= 4'd10;
                end else begin
                    if (frame_ok) begin
                        push_pend <= 1'b1;
                        push_byte <= shift;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    bit_cnt <= 4'd0;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is abandoned without reporting an error.
                if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt <= 4'd0;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign rd_valid = (wr_ptr != rd_ptr);
    assign pop      = rd_en & rd_valid;
    assign push     = push_pend & (~full | pop);
    assign rd_data  = rd_valid ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr[FIFO_AW-1:0]] <= push_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_pend && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Tracking follows every accepted frame, including ones the FIFO had to drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code   <= 8'h00;
            key_down   <= 1'b0;
            key_count  <= 8'h00;
            break_pend <= 1'b0;
        end else if (push_pend) begin
            if (push_byte == 8'hE0) begin
                break_pend <= break_pend;
            end else if (push_byte == 8'hF0) begin
                break_pend <= 1'b1;
            end else if (break_pend) begin
                key_down   <= 1'b0;
                break_pend <= 1'b0;
            end else if (!key_down) begin
                key_code  <= push_byte;
                key_down  <= 1'b1;
                key_count <= key_count + 8'd1;
            end else begin
                key_code <= push_byte;
            end
        end
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed plus randomized bench for ps2_kbd_rx against a queue-based behavioural model.
module tb_ps2_kbd_rx;
    localparam int TMO   = 400;
    localparam int DEPTH = 8;
    localparam int HALF  = 8;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, rd_en;
    logic [7:0] rd_data, key_code, key_count;
    logic       rd_valid, overflow, frame_err, key_down;

    ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .overflow(overflow), .frame_err(frame_err),
        .key_code(key_code), .key_down(key_down), .key_count(key_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int exp_err = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovf;
    logic       m_brk, m_down;
    logic [7:0] m_code;
    int         m_cnt;

    always @(negedge clk) if (frame_err) err_seen++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
        m_brk   = 1'b0;
        m_down  = 1'b0;
        m_code  = 8'h00;
        m_cnt   = 0;
    endtask

    task automatic model_key(input logic [7:0] b);
        if (b == 8'hE0) begin
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_down = 1'b0;
            m_brk  = 1'b0;
        end else if (!m_down) begin
            m_code = b;
            m_down = 1'b1;
            m_cnt  = (m_cnt + 1) % 256;
        end else begin
            m_code = b;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_valid"}, rd_valid, (exp_q.size() > 0));
        chk({tag, ".rd_data"}, rd_data, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
        chk({tag, ".overflow"}, overflow, exp_ovf);
        chk({tag, ".key_code"}, key_code, m_code);
        chk({tag, ".key_down"}, key_down, m_down);
        chk({tag, ".key_count"}, key_count, m_cnt[7:0]);
        chk({tag, ".frame_err_cnt"}, err_seen, exp_err);
    endtask

    task automatic reset_dut(input string tag);
        rst = 1'b1;
        cyc(1);
        model_reset();
        check_all(tag);
        chk({tag, ".frame_err"}, frame_err, 1'b0);
        cyc(1);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_push);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            if (pop_at_push && i == 10) begin
                // Two sync stages plus edge detect put the push three cycles after this edge.
                cyc(3);
                chk("full_head", rd_data, exp_q[0]);
                rd_en = 1'b1;
                cyc(1);
                rd_en = 1'b0;
                void'(exp_q.pop_front());
                cyc(HALF - 4);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_at_push);
        logic        p;
        logic [10:0] bits;
        bit          ok;
        p    = ~(^b) ^ bad_par;
        bits = {~bad_stop, p, b, 1'b0};
        send_bits(bits, 11, pop_at_push);
        cyc(8);
        ok = !bad_stop && (!bad_par || !PAR_CHK);
        if (ok) begin
            model_key(b);
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovf = 1'b1;
        end else begin
            exp_err++;
        end
    endtask

    task automatic do_pop();
        if (exp_q.size() > 0) begin
            chk("pop_data", rd_data, exp_q[0]);
            rd_en = 1'b1;
            cyc(1);
            rd_en = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) do_pop();
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        model_reset();
        cyc(3);
        reset_dut("por");

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_all("t1");
        chk("t1.code_lit", key_code, 8'h1C);
        chk("t1.count_lit", key_count, 8'd1);

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_all("t2");
        chk("t2.count_lit", key_count, 8'd1);
        chk("t2.down_lit", key_down, 1'b0);
        chk("t2.entries", exp_q.size(), 5);
        drain();
        check_all("t2.empty");

        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check_all("t3.parity");
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_all("t3.stop");
        drain();

        rd_en = 1'b1;
        cyc(2);
        rd_en = 1'b0;
        check_all("empty_rd");

        reset_dut("t4.rst");
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b0, 1'b0, 1'b0);
        end
        check_all("t4.ovf");
        drain();
        check_all("t4.drained");

        reset_dut("t4b.rst");
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b0, 1'b0, 1'b0);
        end
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b0, 1'b0, 1'b1);
        check_all("t4b.pushpop");
        drain();
        check_all("t4b.drained");

        send_bits(11'b000_1010_1010, 5, 1'b0);
        cyc(TMO + 8);
        send_frame(8'h32, 1'b0, 1'b0, 1'b0);
        check_all("t5");
        chk("t5.data_lit", rd_data, 8'h32);
        drain();

        send_bits(11'b000_1000_1010, 6, 1'b0);
        reset_dut("t6.rst");
        send_frame(8'h45, 1'b0, 1'b0, 1'b0);
        check_all("t6");
        chk("t6.data_lit", rd_data, 8'h45);

        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 1'b0);
            check_all("rand");
            for (int k = $urandom_range(0, 2); k > 0; k--) do_pop();
        end
        drain();
        check_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
